// File: rtl/decoder_scan_nto2n_if.sv
// Control and decode bus of the N-to-2^N scanning decoder.
// The display/keypad controller holds the master side; the decoder holds the slave side.
interface decoder_scan_nto2n_if #(
  parameter int unsigned N = 2
);
  logic                 en;
  logic [1:0]           mode;
  logic [N-1:0]         b;
  logic [(1 << N)-1:0]  d;
  logic [N-1:0]         code;
  logic                 wrap;

  modport master (
    output en, mode, b,
    input  d, code, wrap
  );

  modport slave (
    input  en, mode, b,
    output d, code, wrap
  );
endinterface

// File: rtl/decoder_scan_nto2n.sv
// N-to-2^N decoder with registered one-hot output, enable, selectable polarity
// and an autonomous up/down scan mode that dwells DWELL cycles on each code.
module decoder_scan_nto2n #(
  parameter int unsigned N          = 2,
  parameter int unsigned DWELL      = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  decoder_scan_nto2n_if.slave  bus
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  mode_e          mode_in;
  mode_e          mode_q,  mode_n;
  logic [N-1:0]   code_q,  code_n;
  logic [DW-1:0]  dwell_q, dwell_n;
  logic           wrap_q,  wrap_n;
  logic           en_q,    en_n;
  logic [W-1:0]   d_q,     d_n;
  logic [W-1:0]   onehot;
  logic           dwell_done;

  assign mode_in    = mode_e'(bus.mode);
  assign dwell_done = (dwell_q == DWELL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_DIRECT;
      code_q  <= '0;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
      en_q    <= 1'b0;
      d_q     <= ACTIVE_LOW ? '1 : '0;
    end else begin
      mode_q  <= mode_n;
      code_q  <= code_n;
      dwell_q <= dwell_n;
      wrap_q  <= wrap_n;
      en_q    <= en_n;
      d_q     <= d_n;
    end
  end

  // A mode change only re-arms the dwell counter; stepping starts next edge.
  always_comb begin
    mode_n  = mode_q;
    code_n  = code_q;
    dwell_n = dwell_q;
    wrap_n  = 1'b0;
    en_n    = bus.en;
    if (bus.en) begin
      mode_n = mode_in;
      if (mode_in != mode_q) begin
        dwell_n = '0;
        if (mode_in == MODE_DIRECT) begin
          code_n = bus.b;
        end
      end else begin
        unique case (mode_in)
          MODE_DIRECT: begin
            code_n  = bus.b;
            dwell_n = '0;
          end
          MODE_SCAN_UP: begin
            if (dwell_done) begin
              dwell_n = '0;
              code_n  = code_q + N'(1);
              wrap_n  = &code_q;
            end else begin
              dwell_n = dwell_q + DW'(1);
            end
          end
          MODE_SCAN_DOWN: begin
            if (dwell_done) begin
              dwell_n = '0;
              code_n  = code_q - N'(1);
              wrap_n  = ~|code_q;
            end else begin
              dwell_n = dwell_q + DW'(1);
            end
          end
          MODE_HOLD: begin
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Decode the next code so d lands on the same edge as code.
  always_comb begin
    onehot = '0;
    if (en_n) begin
      onehot[code_n] = 1'b1;
    end
    d_n = ACTIVE_LOW ? ~onehot : onehot;
  end

  assign bus.d    = d_q;
  assign bus.code = code_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Randomised self-checking bench: two decoder configurations share clk/rst/en/mode
// and are compared every cycle against an integer reference model.
module tb_decoder_scan_nto2n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_scan_nto2n_if #(.N(3)) bus_a ();
  decoder_scan_nto2n_if #(.N(1)) bus_b ();

  decoder_scan_nto2n #(.N(3), .DWELL(3), .ACTIVE_LOW(1'b0)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  decoder_scan_nto2n #(.N(1), .DWELL(1), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int p_n   [2] = '{3, 1};
  int p_dw  [2] = '{3, 1};
  int p_al  [2] = '{0, 1};

  int m_code  [2];
  int m_dwell [2];
  int m_modeq [2];
  int m_wrap  [2];
  int m_enq   [2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference behaviour: code modulo 2^N, dwell measured in whole cycles.
  task automatic model_step(input int i, input bit r, input bit e, input int md, input int bv);
    int size;
    size = 1 << p_n[i];
    if (r) begin
      m_code[i] = 0; m_dwell[i] = 0; m_wrap[i] = 0; m_enq[i] = 0; m_modeq[i] = 0;
    end else if (!e) begin
      m_enq[i] = 0; m_wrap[i] = 0;
    end else begin
      m_enq[i] = 1;
      m_wrap[i] = 0;
      if (md != m_modeq[i]) begin
        m_dwell[i] = 0;
        if (md == 0) m_code[i] = bv;
        m_modeq[i] = md;
      end else if (md == 0) begin
        m_code[i] = bv;
        m_dwell[i] = 0;
      end else if (md == 1 || md == 2) begin
        if (m_dwell[i] + 1 >= p_dw[i]) begin
          m_dwell[i] = 0;
          if (md == 1) begin
            m_wrap[i] = (m_code[i] == size - 1);
            m_code[i] = (m_code[i] + 1) % size;
          end else begin
            m_wrap[i] = (m_code[i] == 0);
            m_code[i] = (m_code[i] + size - 1) % size;
          end
        end else begin
          m_dwell[i] = m_dwell[i] + 1;
        end
      end
    end
  endtask

  function automatic longint exp_d(input int i);
    longint oh;
    longint mask;
    mask = (longint'(1) << (1 << p_n[i])) - 1;
    oh = m_enq[i] ? (longint'(1) << m_code[i]) : 0;
    if (p_al[i] != 0) oh = ~oh & mask;
    return oh;
  endfunction

  task automatic cycle();
    bit r, e;
    int md, ba, bb;
    r  = rst;
    e  = bus_a.en;
    md = int'(bus_a.mode);
    ba = int'(bus_a.b);
    bb = int'(bus_b.b);
    @(posedge clk);
    model_step(0, r, e, md, ba);
    model_step(1, r, e, md, bb);
    #1;
    check("a.d",    longint'(bus_a.d),    exp_d(0));
    check("a.code", longint'(bus_a.code), longint'(m_code[0]));
    check("a.wrap", longint'(bus_a.wrap), longint'(m_wrap[0]));
    check("b.d",    longint'(bus_b.d),    exp_d(1));
    check("b.code", longint'(bus_b.code), longint'(m_code[1]));
    check("b.wrap", longint'(bus_b.wrap), longint'(m_wrap[1]));
  endtask

  task automatic drive(input bit e, input logic [1:0] md, input logic [2:0] ba);
    bus_a.en   = e;
    bus_b.en   = e;
    bus_a.mode = md;
    bus_b.mode = md;
    bus_a.b    = ba;
    bus_b.b    = ba[0];
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'b00, 3'd0);
    repeat (2) cycle();

    // Release into direct mode with a known code
    rst = 1'b0;
    drive(1'b1, 2'b00, 3'd2);
    cycle();

    // Direct sweep over every code
    for (int unsigned k = 0; k < 8; k++) begin
      drive(1'b1, 2'b00, 3'(k));
      cycle();
    end

    // Scan up across a wrap
    drive(1'b1, 2'b01, 3'd5);
    repeat (30) cycle();

    // Scan down with an enable dropout mid-dwell
    drive(1'b1, 2'b10, 3'd0);
    repeat (4) cycle();
    drive(1'b0, 2'b10, 3'd0);
    repeat (3) cycle();
    drive(1'b1, 2'b10, 3'd0);
    repeat (25) cycle();

    // Hold, then resume scanning
    drive(1'b1, 2'b11, 3'd7);
    repeat (5) cycle();
    drive(1'b1, 2'b01, 3'd7);
    repeat (8) cycle();

    // Reset mid-scan, then direct load
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive(1'b1, 2'b00, 3'd1);
    cycle();
    drive(1'b1, 2'b01, 3'd1);
    repeat (6) cycle();

    // Random traffic
    for (int unsigned k = 0; k < 1500; k++) begin
      logic [1:0] md;
      md = bus_a.mode;
      if ($urandom_range(0, 11) == 0) md = 2'($urandom_range(0, 3));
      drive(($urandom_range(0, 9) != 0), md, 3'($urandom));
      rst = ($urandom_range(0, 79) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_scan_nto2n.md
Name: decoder_scan_nto2n

Overview:
Parametrised successor to the team's 2-to-4 decoder. Generalises decoding to N-to-2^N with a registered one-hot output, an enable, and selectable output polarity. Adds an autonomous scan mode: an internal counter steps the decoded code up or down at a programmable dwell rate. Intended for digit/row select in multiplexed LED and 7-seg display drivers, and for scanned keypad columns.

Parameters:
N, 2, code width; output width is 2^N; legal range 1..6
DWELL, 4, clock cycles each code is held in scan modes; legal range >= 1
ACTIVE_LOW, 0, 1 = inverts every bit of d (asserted bit low, others high)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  1 = decoder active; 0 = all d bits inactive, state frozen
mode  input  2  00 direct, 01 scan-up, 10 scan-down, 11 hold
b  input  N  code to decode in direct mode; bit N-1 is the MSB
d  output  2^N  registered one-hot decode of code; d[k] asserted iff code==k and en_q
code  output  N  current registered code
wrap  output  1  one-cycle pulse, registered with code, when a scan step wraps

Behaviour:
- All state updates on the rising clk edge. rst has priority over every other input.
- Reset values:
  - code=0, dwell counter=0, wrap=0, internal en_q=0, mode_q=00.
  - d all inactive: all 0, or all 1 when ACTIVE_LOW=1.
- d is registered and updates on the same edge as code, so d always equals onehot(code) gated by en_q. d never shows zero or multiple asserted bits while en_q=1.
- Direct mode (00), en=1:
  - code<=b every cycle.
  - Latency: b sampled at edge t appears on code and d after edge t (1 cycle).
  - Dwell counter is held at 0. wrap=0.
- Scan-up mode (01), en=1:
  - Dwell counter counts 0..DWELL-1.
  - At terminal count, dwell<=0 and code<=code+1 mod 2^N.
  - wrap=1 for exactly the cycle in which code goes 2^N-1 -> 0; otherwise wrap=0.
  - DWELL=1: code steps every cycle.
- Scan-down mode (10): same as scan-up, but code<=code-1 mod 2^N. wrap=1 when code goes 0 -> 2^N-1.
- Hold mode (11): code and dwell counter frozen, d continues to show code, wrap=0.
- en=0:
  - code and dwell counter frozen, wrap=0.
  - d goes inactive on the next edge (en_q=0).
  - When en returns to 1, d shows the frozen code after the next edge, and scanning resumes from the frozen dwell count.
- Mode change (mode != mode_q with en=1):
  - Dwell counter cleared to 0 on that edge, and no step occurs on that edge.
  - Scanning starts from the current code, not from 0.
  - Direct mode loads b on the change edge.
- b is ignored in every mode except direct.
- Reset asserted mid-scan: all outputs return to reset values on that edge. After release, scanning restarts from code 0 with a full dwell period.
- N=1 case: d is 2 bits; wrap pulses on every scan step.

Test Plan:
- Reset, N=2, ACTIVE_LOW=0: hold rst 2 cycles -> d=0000, code=0, wrap=0. Release with en=1, mode=00, b=2 -> after 1 edge code=2, d=0100.
- Direct sweep, N=3: b=0..7 on consecutive cycles with en=1 -> d=00000001..10000000, each 1 cycle after b, exactly one bit set.
- Scan-up, N=2, DWELL=4: from code=0, mode=01 for 20 cycles -> code holds each value 4 cycles (0,1,2,3,0). wrap=1 only on the 3->0 edge.
- Scan-down with en glitch, N=2, DWELL=2: en=0 for 3 cycles mid-dwell -> d=0000 one edge later, code frozen. en=1 -> d restored next edge, remaining dwell count honoured. 0->3 step pulses wrap.
- Mode change and hold: scan-up at code=2 with dwell=1, switch to 11 -> code stays 2, d=0100. Switch to 01 -> dwell restarts at 0, next step after DWELL full cycles.
- ACTIVE_LOW=1, N=2, rst mid-scan: outputs d=1111, code=0. After release, direct b=1 -> d=1101.
